// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master arbiter: state encoding, field widths
// and the round-robin pointer helper.
package i2c_pkg;

    localparam int MAX_REQ = 4;
    localparam int NBYTE_W = 6;
    localparam int DEV_W   = 7;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_BUSY    = 2'd2
    } arb_state_t;

    // Index following idx, wrapping at num_req.
    function automatic logic [1:0] rr_next(input logic [1:0] idx, input int unsigned num_req);
        logic [2:0] nxt;
        nxt = {1'b0, idx} + 3'd1;
        if ({29'd0, nxt} >= num_req) begin
            return 2'd0;
        end
        return nxt[1:0];
    endfunction

endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Requester-side and master-side signal bundle around the arbiter.
// slave:  the arbiter's view. master: the environment's view.
interface i2c_master_arbiter_if #(parameter int NUM_REQ = 2);

    logic [NUM_REQ-1:0]                   req;
    logic [NUM_REQ-1:0]                   req_go;
    logic [NUM_REQ-1:0]                   req_stop;
    logic [NUM_REQ-1:0]                   req_rw;
    logic [i2c_pkg::NBYTE_W*NUM_REQ-1:0]  req_nbyte;
    logic [i2c_pkg::DEV_W*NUM_REQ-1:0]    req_dev_add;
    logic [i2c_pkg::BYTE_W*NUM_REQ-1:0]   req_regaddr;
    logic [i2c_pkg::BYTE_W*NUM_REQ-1:0]   req_wdata;

    logic [NUM_REQ-1:0]                   gnt;
    logic [NUM_REQ-1:0]                   req_done;
    logic                                 rsp_ack_e;
    logic [i2c_pkg::BYTE_W-1:0]           rsp_rdata;
    logic                                 timeout_err;

    logic                                 Master_Go;
    logic                                 Master_Stop;
    logic                                 Master_RW;
    logic [i2c_pkg::NBYTE_W-1:0]          Master_NumOfBytes;
    logic [i2c_pkg::DEV_W-1:0]            Master_SlaveAddr;
    logic [i2c_pkg::BYTE_W-1:0]           Master_SlaveRegAddr;
    logic [i2c_pkg::BYTE_W-1:0]           Master_DataWriteReg;
    logic                                 Master_Done;
    logic                                 Master_Ready;
    logic                                 Master_ACK;
    logic [i2c_pkg::BYTE_W-1:0]           Master_ReadData;

    modport slave (
        input  req, req_go, req_stop, req_rw, req_nbyte, req_dev_add, req_regaddr, req_wdata,
        input  Master_Done, Master_Ready, Master_ACK, Master_ReadData,
        output gnt, req_done, rsp_ack_e, rsp_rdata, timeout_err,
        output Master_Go, Master_Stop, Master_RW, Master_NumOfBytes, Master_SlaveAddr,
        output Master_SlaveRegAddr, Master_DataWriteReg
    );

    modport master (
        output req, req_go, req_stop, req_rw, req_nbyte, req_dev_add, req_regaddr, req_wdata,
        output Master_Done, Master_Ready, Master_ACK, Master_ReadData,
        input  gnt, req_done, rsp_ack_e, rsp_rdata, timeout_err,
        input  Master_Go, Master_Stop, Master_RW, Master_NumOfBytes, Master_SlaveAddr,
        input  Master_SlaveRegAddr, Master_DataWriteReg
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin first-one search: the first set req bit at or above ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [1:0]         idx,
    output logic               found
);

    logic [2:0] pos;

    // Walk NUM_REQ positions starting at ptr and keep the first hit.
    always_comb begin
        idx   = 2'd0;
        found = 1'b0;
        pos   = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr} + 3'(k);
            if (pos >= 3'(NUM_REQ)) begin
                pos = pos - 3'(NUM_REQ);
            end
            if (!found && (|(req & (NUM_REQ'(1) << pos)))) begin
                found = 1'b1;
                idx   = pos[1:0];
            end
        end
        onehot = found ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master engine between NUM_REQ
// requesters. A grant is held for as long as the owner keeps req high, so a
// multi-transaction sequence is never interleaved with another requester.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | no owner; grant the next requester once the master is ready
//   ST_GRANTED | owner holds the engine between transactions; watchdog runs
//   ST_BUSY    | owner's transaction in flight; waits for Master_Ready
module i2c_master_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    i2c_master_arbiter_if.slave   bus
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [1:0]          idx_q, idx_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic                tout_q, tout_d;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [1:0]          pick_idx;
    logic                pick_found;
    logic                own_req;
    logic                own_go;

    logic                m_go, m_stop, m_rw;
    logic [NBYTE_W-1:0]  m_nbyte;
    logic [DEV_W-1:0]    m_dev;
    logic [BYTE_W-1:0]   m_reg;
    logic [BYTE_W-1:0]   m_wdata;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    assign own_req = |(bus.req & gnt_q);
    assign own_go  = |(bus.req_go & gnt_q);

    // Next-state, grant, pointer and watchdog decisions.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        wdog_d  = wdog_q;
        tout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wdog_d = '0;
                if (pick_found && bus.Master_Ready) begin
                    gnt_d   = pick_onehot;
                    idx_d   = pick_idx;
                    state_d = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                // A go in the same cycle as a req drop wins; release comes later.
                if (own_go) begin
                    wdog_d  = '0;
                    state_d = ST_BUSY;
                end else if (!own_req || (wdog_q == WD_LAST)) begin
                    tout_d  = own_req;
                    gnt_d   = '0;
                    ptr_d   = rr_next(idx_q, NUM_REQ);
                    wdog_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_BUSY: begin
                wdog_d = '0;
                if (bus.Master_Ready && !own_go) begin
                    state_d = ST_GRANTED;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                wdog_d  = '0;
            end
        endcase
    end

    // Arbiter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            idx_q   <= 2'd0;
            ptr_q   <= 2'd0;
            wdog_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
            tout_q  <= tout_d;
        end
    end

    // Steer the granted requester's controls to the master; zero when ungranted.
    always_comb begin
        m_go    = 1'b0;
        m_stop  = 1'b0;
        m_rw    = 1'b0;
        m_nbyte = '0;
        m_dev   = '0;
        m_reg   = '0;
        m_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                m_go    = bus.req_go[i] & (state_q != ST_IDLE);
                m_stop  = bus.req_stop[i];
                m_rw    = bus.req_rw[i];
                m_nbyte = bus.req_nbyte[i*NBYTE_W +: NBYTE_W];
                m_dev   = bus.req_dev_add[i*DEV_W +: DEV_W];
                m_reg   = bus.req_regaddr[i*BYTE_W +: BYTE_W];
                m_wdata = bus.req_wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign bus.Master_Go           = m_go;
    assign bus.Master_Stop         = m_stop;
    assign bus.Master_RW           = m_rw;
    assign bus.Master_NumOfBytes   = m_nbyte;
    assign bus.Master_SlaveAddr    = m_dev;
    assign bus.Master_SlaveRegAddr = m_reg;
    assign bus.Master_DataWriteReg = m_wdata;

    assign bus.gnt         = gnt_q;
    assign bus.req_done    = gnt_q & {NUM_REQ{bus.Master_Done}};
    assign bus.rsp_ack_e   = bus.Master_ACK;
    assign bus.rsp_rdata   = bus.Master_ReadData;
    assign bus.timeout_err = tout_q;

endmodule
